usb_in_packetizer: RTL
======================

// Module: usb_in_packetizer
// PURPOSE
//  Downstream of the byte queue's read port, in the r_clk domain. Collects the queue's byte stream
//  into two ping-pong packet banks and answers host IN tokens: with DATA0/DATA1 + payload + CRC16,
//  or with NAK when no packet is ready. Output is a byte stream to the USB serializer (NRZI/bit-stuff).
//  Retransmits the same packet until the host ACKs it.
// PARAMETERS
//  MAX_PKT  64    max payload bytes per packet; also depth of each bank (power of 2, 8..512)
//  TIMEOUT  1024  r_clk cycles without a new byte before a partially filled bank is closed
// PORTS
//  r_clk     in   1  clock; same clock as the queue read side
//  rst       in   1  synchronous, active-low reset
//  q_empty   in   1  queue empty flag; the queue pops every r_clk edge while this is low
//  q_data    in   8  queue data_out; holds the popped byte one cycle after a non-empty edge
//  in_token  in   1  1-cycle pulse: host IN token addressed to this endpoint
//  in_ack    in   1  1-cycle pulse: host ACK received for the last DATA packet
//  tx_ready  in   1  serializer accepts tx_data this cycle
//  tx_valid  out  1  tx_data valid
//  tx_data   out  8  packet byte
//  tx_last   out  1  marks the final byte of a packet
//  overflow  out  1  sticky flag: a byte was dropped because both banks were held
// BEHAVIOUR
//  Reset (rst==0 at a clock edge):
//   - outputs: tx_valid=0, tx_data=0, tx_last=0, overflow=0.
//   - both banks empty, fill bank=0, data toggle=DATA0, FSM=IDLE, timeout counter=0.
//   - reset mid-packet aborts immediately; no further byte is presented.
//  Input capture:
//   - in_vld <= ~q_empty (registered). When in_vld=1, q_data is a valid byte.
//   - There is no backpressure: every valid byte is either written or dropped.
//  Filling:
//   - A valid byte is written to the fill bank at index cnt; cnt increments.
//   - The bank closes in the same cycle its cnt reaches MAX_PKT.
//   - The bank also closes when cnt>0 and TIMEOUT cycles pass with no valid byte.
//   - On close: bank marked ready, cnt latched, fill switches to the other bank if it is free.
//   - If the other bank is held, further bytes are dropped and overflow<=1 (cleared only by reset).
//   - A closed bank is held until ACKed.
//  TX handshake:
//   - A byte transfers when tx_valid & tx_ready.
//   - tx_data, tx_last and tx_valid stay stable until the transfer.
//   - tx_valid stays high for all bytes of a packet.
//  FSM:
//   - IDLE -> SEND_NAK on in_token with no ready bank; emits 0x5A with tx_last, then IDLE.
//   - IDLE -> SEND_PID on in_token with the oldest ready bank selected (tx bank).
//     PID = toggle ? 0x4B (DATA1) : 0xC3 (DATA0).
//   - SEND_PID -> SEND_DATA (cnt>0) or SEND_CRC_LO (cnt==0).
//   - SEND_DATA streams bytes 0..cnt-1, then SEND_CRC_LO.
//   - CRC_LO, then CRC_HI with tx_last=1, then WAIT_HS.
//   - WAIT_HS on in_ack: free the tx bank, toggle^=1, go to IDLE.
//   - WAIT_HS on in_token: resend the same bank with the same PID (retransmit).
//   - in_token or in_ack outside IDLE/WAIT_HS is ignored.
//  CRC16:
//   - Reflected poly 0xA001, init 0xFFFF, over payload only.
//   - Transmitted value is ~crc, low byte first. An empty payload gives 0x0000.
//  Simultaneous events:
//   - A byte arrives in the same cycle its bank is freed: the write and the free both take effect.
//   - A bank closes in the same cycle as in_token in IDLE: the closed bank is used (no NAK).
//  Latency: in_token to first tx_valid = 1 cycle.
//  Widths: cnt is $clog2(MAX_PKT)+1 bits; timeout counter is $clog2(TIMEOUT)+1 bits and saturates.
// STRUCTURE
//  - usb_pkg holds PID_DATA0=8'hC3, PID_DATA1=8'h4B, PID_NAK=8'h5A, CRC16_POLY=16'hA001,
//    CRC16_INIT=16'hFFFF, and the FSM state enum.
//  - Sub-module usb_crc16: byte-wide CRC update (init/en/din -> crc); computed while streaming.
//  - Banks: one (* ram_style="block" *) memory of 2*MAX_PKT bytes, address {bank, index}.
// TESTING
//  1. Push 64 bytes 0x00..0x3F, then pulse in_token.
//     -> C3, 00..3F, CRC lo, CRC hi (matching the SW model); tx_last only on CRC hi.
//  2. Push 3 bytes, idle TIMEOUT cycles, then in_token.
//     -> C3 + 3 bytes + CRC; before the timeout elapses, in_token gives a single 5A with tx_last=1.
//  3. After case 1, pulse in_token again without in_ack -> identical C3 packet.
//     Then in_ack, fill again, in_token -> PID 4B.
//  4. Stream 200 bytes with no tokens (MAX_PKT=64) -> banks hold 0..127, overflow=1 from byte 128.
//     After two token+ack cycles the packets carry bytes 0..63, then 64..127.
//  5. Hold tx_ready low randomly during case 1 -> same byte sequence, tx_data stable while stalled.
//  6. Assert rst for 1 cycle mid SEND_DATA.
//     -> tx_valid=0 the next cycle, overflow=0; next in_token gives 5A; next packet uses PID C3.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants, FSM state encoding and the byte-wide CRC16 step for the
// USB IN packetizer.
package usb_pkg;

    localparam logic [7:0]  PID_DATA0  = 8'hC3;
    localparam logic [7:0]  PID_DATA1  = 8'h4B;
    localparam logic [7:0]  PID_NAK    = 8'h5A;
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_NAK,
        ST_SEND_PID,
        ST_SEND_DATA,
        ST_SEND_CRC_LO,
        ST_SEND_CRC_HI,
        ST_WAIT_HS
    } tx_state_t;

    // Reflected CRC16: fold the byte into the low end, then shift out 8 bits.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] din);
        logic [15:0] c;
        c = crc_in ^ {8'h00, din};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Running CRC16 over the payload bytes as they leave the packetizer.
// i_init wins over i_en so a retransmit restarts cleanly from the PID byte.
module usb_crc16 import usb_pkg::*; (
    input  logic        r_clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_din,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge r_clk) begin
        if (!rst || i_init) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_byte(r_crc, i_din);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_in_packetizer.sv
// Packs the queue byte stream into two ping-pong banks and answers IN tokens
// with DATA0/DATA1 + payload + CRC16 (retransmitted until ACK) or NAK.
//
//  state          | meaning
//  ST_IDLE        | waiting for an IN token
//  ST_SEND_NAK    | presenting 0x5A (last byte)
//  ST_SEND_PID    | presenting DATA0/DATA1 PID of the tx bank
//  ST_SEND_DATA   | streaming payload bytes 0..cnt-1
//  ST_SEND_CRC_LO | presenting ~crc[7:0]
//  ST_SEND_CRC_HI | presenting ~crc[15:8] (last byte)
//  ST_WAIT_HS     | waiting for ACK (free bank) or token (retransmit)
module usb_in_packetizer import usb_pkg::*; #(
    parameter int MAX_PKT = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic       r_clk,
    input  logic       rst,
    input  logic       i_q_empty,
    input  logic [7:0] i_q_data,
    input  logic       i_in_token,
    input  logic       i_in_ack,
    input  logic       i_tx_ready,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_last,
    output logic       o_overflow
);

    localparam int IW = $clog2(MAX_PKT);
    localparam int CW = IW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    tx_state_t     r_state, w_state_nxt;
    logic          r_in_vld;
    logic [1:0]    r_ready;
    logic [CW-1:0] r_cnt [2];
    logic [CW-1:0] r_fill_cnt;
    logic          r_fill_bank;
    logic          r_head;
    logic          r_tx_bank;
    logic          r_toggle;
    logic [TW-1:0] r_to_cnt;
    logic [IW-1:0] r_idx;
    logic [7:0]    r_rd_data;
    logic          r_overflow;
    (* ram_style = "block" *) logic [7:0] r_mem [2*MAX_PKT];

    logic          w_free, w_wr, w_close, w_fill_bank, w_tx_sel, w_any_ready, w_crc_en;
    logic [1:0]    w_ready_eff, w_ready_nxt;
    logic [CW-1:0] w_cnt_nxt, w_tx_cnt;
    logic [IW-1:0] w_rd_idx;
    logic [15:0]   w_crc;

    assign w_free = (r_state == ST_WAIT_HS) && i_in_ack;

    // A bank freed this cycle is immediately writable again.
    always_comb begin
        w_ready_eff = r_ready;
        if (w_free) w_ready_eff[r_tx_bank] = 1'b0;
        w_ready_nxt = w_ready_eff;
        if (w_close) w_ready_nxt[w_fill_bank] = 1'b1;
    end

    assign w_fill_bank = w_ready_eff[r_fill_bank] ? ~r_fill_bank : r_fill_bank;
    assign w_wr        = r_in_vld && !w_ready_eff[w_fill_bank];
    assign w_cnt_nxt   = r_fill_cnt + CW'(w_wr);
    assign w_close     = (w_wr && (w_cnt_nxt == CNT_MAX)) ||
                         (!r_in_vld && (r_fill_cnt != '0) && (r_to_cnt == TO_LAST));
    assign w_any_ready = (|r_ready) || w_close;
    assign w_tx_sel    = r_ready[r_head] ? r_head : w_fill_bank;
    assign w_tx_cnt    = r_cnt[r_tx_bank];
    assign w_crc_en    = (r_state == ST_SEND_DATA) && i_tx_ready;

    always_comb begin
        w_rd_idx = r_idx;
        if (r_state == ST_SEND_PID) w_rd_idx = '0;
        else if (w_crc_en)          w_rd_idx = r_idx + IW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        o_tx_valid  = 1'b0;
        o_tx_data   = '0;
        o_tx_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_in_token) w_state_nxt = w_any_ready ? ST_SEND_PID : ST_SEND_NAK;
            end
            ST_SEND_NAK: begin
                o_tx_valid = 1'b1;
                o_tx_data  = PID_NAK;
                o_tx_last  = 1'b1;
                if (i_tx_ready) w_state_nxt = ST_IDLE;
            end
            ST_SEND_PID: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_toggle ? PID_DATA1 : PID_DATA0;
                if (i_tx_ready) w_state_nxt = (w_tx_cnt != '0) ? ST_SEND_DATA : ST_SEND_CRC_LO;
            end
            ST_SEND_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_data  = r_rd_data;
                if (i_tx_ready && ({1'b0, r_idx} == w_tx_cnt - CW'(1))) w_state_nxt = ST_SEND_CRC_LO;
            end
            ST_SEND_CRC_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = ~w_crc[7:0];
                if (i_tx_ready) w_state_nxt = ST_SEND_CRC_HI;
            end
            ST_SEND_CRC_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = ~w_crc[15:8];
                o_tx_last  = 1'b1;
                if (i_tx_ready) w_state_nxt = ST_WAIT_HS;
            end
            ST_WAIT_HS: begin
                if (i_in_ack)        w_state_nxt = ST_IDLE;
                else if (i_in_token) w_state_nxt = ST_SEND_PID;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read address runs one index ahead so r_rd_data matches r_idx in SEND_DATA.
    always_ff @(posedge r_clk) begin
        if (w_wr) r_mem[{w_fill_bank, r_fill_cnt[IW-1:0]}] <= i_q_data;
        r_rd_data <= r_mem[{r_tx_bank, w_rd_idx}];
    end

    always_ff @(posedge r_clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_in_vld    <= 1'b0;
            r_ready     <= '0;
            r_cnt[0]    <= '0;
            r_cnt[1]    <= '0;
            r_fill_cnt  <= '0;
            r_fill_bank <= 1'b0;
            r_head      <= 1'b0;
            r_tx_bank   <= 1'b0;
            r_toggle    <= 1'b0;
            r_to_cnt    <= '0;
            r_idx       <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_vld    <= ~i_q_empty;
            r_idx       <= w_rd_idx;
            r_fill_bank <= w_fill_bank;
            r_ready     <= w_ready_nxt;
            if (r_in_vld && !w_wr) r_overflow <= 1'b1;
            if (w_close) begin
                r_cnt[w_fill_bank] <= w_cnt_nxt;
                r_fill_cnt         <= '0;
                if (!w_ready_eff[~w_fill_bank]) r_head <= w_fill_bank;
            end else begin
                r_fill_cnt <= w_cnt_nxt;
                if (w_free) r_head <= ~r_tx_bank;
            end
            if (r_in_vld || w_close || (r_fill_cnt == '0)) r_to_cnt <= '0;
            else if (r_to_cnt != '1)                       r_to_cnt <= r_to_cnt + TW'(1);
            if ((r_state == ST_IDLE) && i_in_token && w_any_ready) r_tx_bank <= w_tx_sel;
            if (w_free) r_toggle <= ~r_toggle;
        end
    end

    usb_crc16 u_crc (
        .r_clk  (r_clk),
        .rst    (rst),
        .i_init (r_state == ST_SEND_PID),
        .i_en   (w_crc_en),
        .i_din  (r_rd_data),
        .o_crc  (w_crc)
    );

    assign o_overflow = r_overflow;

endmodule
